gemm_tile_engine: RTL and testbench
===================================

GEMM_TILE_ENGINE -- requirements
Module: gemm_tile_engine

Interface
REQ-001 SHALL have parameter MAX_M, default 4, maximum rows of A and C.
REQ-002 SHALL have parameter MAX_K, default 4, maximum inner dimension.
REQ-003 SHALL have parameter MAX_N, default 4, maximum columns of B and C; MAX_N*32 = 128.
REQ-004 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-005 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-006 SHALL have port in_valid  input  1  job request; dims sampled in IDLE.
REQ-007 SHALL have ports M_dim, K_dim, N_dim  input  8 each  job dimensions.
REQ-008 SHALL have port a_valid, a_data  input  1, 32  A element stream, row-major; element = signed a_data[7:0].
REQ-009 SHALL have port b_valid, b_data  input  1, 32  B element stream, row-major; element = signed b_data[7:0].
REQ-010 SHALL have port start_compute  input  1  compute trigger from controller.
REQ-011 SHALL have ports out_valid, out_ready  output/input  1 each  C-row handshake.
REQ-012 SHALL have port systolic_out_C  output  128  one C row; column j in bits [32j+31:32j], signed int32.
REQ-013 SHALL have ports busy, done, err  output  1 each  status; done and err are one-cycle pulses.

Function
REQ-014 SHALL implement states IDLE, LOAD_A, LOAD_B, WAIT_START, COMPUTE, DRAIN.
REQ-015 IDLE: on in_valid with all dims in 1..MAX, SHALL latch dims, clear accumulators, go to LOAD_A next cycle.
REQ-016 IDLE: on in_valid with any dim 0 or > its MAX, SHALL pulse err one cycle and stay IDLE.
REQ-017 LOAD_A: SHALL store each a_valid element at the next row-major index; after M*K elements go to LOAD_B.
REQ-018 LOAD_B: SHALL store each b_valid element likewise; after K*N elements go to WAIT_START.
REQ-019 a_valid outside LOAD_A and b_valid outside LOAD_B SHALL be ignored; excess elements dropped.
REQ-020 WAIT_START: first cycle with start_compute=1 SHALL enter COMPUTE; start_compute in any other state ignored.
REQ-021 COMPUTE: one cycle per (i,k), k fastest; C[i][j] += A[i][k]*B[k][j] for all j < N in parallel; exactly M*K cycles, then DRAIN.
REQ-022 Products SHALL be 16-bit signed, sign-extended into 32-bit accumulators; no overflow possible at MAX dims.
REQ-023 DRAIN: SHALL present row i (i = 0..M-1) with out_valid=1, holding systolic_out_C stable until out_ready=1; columns j >= N SHALL read zero.
REQ-024 Row advances only on out_valid & out_ready; after row M-1 transfers, done SHALL pulse in the next cycle and state returns to IDLE.
REQ-025 out_valid SHALL never depend combinationally on out_ready.
REQ-026 busy SHALL be 1 in every state except IDLE.
REQ-027 M=K=N=1 SHALL be legal: one A, one B, one compute cycle, one output row.

Reset
REQ-028 reset SHALL force IDLE, counters and accumulators to 0, busy/out_valid/done/err to 0, systolic_out_C to 0, in any state including mid-COMPUTE or mid-DRAIN.
REQ-029 A/B element buffers need not be reset; they are fully rewritten before use.

Configuration
REQ-030 With GEMM_RELU_EN defined, each output column SHALL be max(C,0) on systolic_out_C; accumulators keep signed values.
REQ-031 Without GEMM_RELU_EN, systolic_out_C SHALL carry raw signed accumulators.

Structure
REQ-032 Package gemm_pkg SHALL hold the state enum, ELEM_W=8, ACC_W=32, and default MAX_M/K/N.
REQ-033 Sub-module gemm_mac_row SHALL implement MAX_N parallel MACs with clear and enable; instantiated once.

Verification
REQ-034 M=K=N=2, A=[1,2;3,4], B=identity, start -> rows {1,2,0,0},{3,4,0,0}, done pulse.
REQ-035 M=K=N=4, all A=-1, all B=2 -> every C element -8 (0 with GEMM_RELU_EN).
REQ-036 out_ready low 3 cycles on row 1 -> row 1 held stable, no row skipped or duplicated.
REQ-037 in_valid with K_dim=5 -> err pulse, busy stays 0; N_dim=0 likewise.
REQ-038 reset asserted mid-COMPUTE -> next cycle IDLE, all outputs 0; following 1x1x1 job (7*-3) -> -21.
REQ-039 start_compute high during LOAD_B and extra a_valid in LOAD_B -> ignored; result unchanged.

Source files
------------

// File: rtl/gemm_pkg.sv
// gemm_pkg: shared types and constants for the GEMM tile engine.
// Holds the FSM state enum, element/accumulator widths and default tile limits.
package gemm_pkg;

    localparam int ELEM_W    = 8;
    localparam int ACC_W     = 32;
    localparam int PROD_W    = 2 * ELEM_W;
    localparam int DEF_MAX_M = 4;
    localparam int DEF_MAX_K = 4;
    localparam int DEF_MAX_N = 4;

    typedef enum logic [2:0] {
        IDLE,
        LOAD_A,
        LOAD_B,
        WAIT_START,
        COMPUTE,
        DRAIN
    } state_t;

    function automatic logic [ACC_W-1:0] relu(input logic [ACC_W-1:0] v);
        return v[ACC_W-1] ? '0 : v;
    endfunction

endpackage

// File: rtl/gemm_tile_engine_if.sv
// gemm_tile_engine_if: job request, A/B element streams, start trigger,
// C-row valid/ready handshake and status. master = controller, slave = engine.
interface gemm_tile_engine_if
    import gemm_pkg::*;
#(
    parameter int MAX_N = DEF_MAX_N
);
    logic                     in_valid;
    logic [7:0]               M_dim;
    logic [7:0]               K_dim;
    logic [7:0]               N_dim;
    logic                     a_valid;
    logic [31:0]              a_data;
    logic                     b_valid;
    logic [31:0]              b_data;
    logic                     start_compute;
    logic                     out_valid;
    logic                     out_ready;
    logic [MAX_N*ACC_W-1:0]   systolic_out_C;
    logic                     busy;
    logic                     done;
    logic                     err;

    modport master (
        output in_valid, M_dim, K_dim, N_dim,
        output a_valid, a_data, b_valid, b_data,
        output start_compute, out_ready,
        input  out_valid, systolic_out_C, busy, done, err
    );

    modport slave (
        input  in_valid, M_dim, K_dim, N_dim,
        input  a_valid, a_data, b_valid, b_data,
        input  start_compute, out_ready,
        output out_valid, systolic_out_C, busy, done, err
    );

endinterface

// File: rtl/gemm_mac_row.sv
// gemm_mac_row: MAX_N parallel signed 8x8 MACs into 32-bit accumulators.
// Ports: clk, reset, clr_i (restart sum), en_i (accumulate), a_i, b_i lanes, sum_o (next sums).
module gemm_mac_row
    import gemm_pkg::*;
#(
    parameter int MAX_N = DEF_MAX_N
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     clr_i,
    input  logic                     en_i,
    input  logic signed [ELEM_W-1:0] a_i,
    input  logic [MAX_N*ELEM_W-1:0]  b_i,
    output logic [MAX_N*ACC_W-1:0]   sum_o
);

    logic [MAX_N*ACC_W-1:0] acc_q;
    logic [MAX_N*ACC_W-1:0] acc_d;

    for (genvar j = 0; j < MAX_N; j++) begin : g_mac
        logic signed [PROD_W-1:0] prod;
        logic signed [ACC_W-1:0]  base;
        assign prod = PROD_W'(a_i) * PROD_W'($signed(b_i[j*ELEM_W +: ELEM_W]));
        // clr with en starts a fresh sum from this cycle's product
        assign base = clr_i ? '0 : $signed(acc_q[j*ACC_W +: ACC_W]);
        assign acc_d[j*ACC_W +: ACC_W] = base + ACC_W'(prod);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            acc_q <= '0;
        end else if (en_i) begin
            acc_q <= acc_d;
        end else if (clr_i) begin
            acc_q <= '0;
        end
    end

    assign sum_o = acc_d;

endmodule

// File: rtl/gemm_tile_engine.sv
// gemm_tile_engine: loads A (MxK) and B (KxN) int8 tiles, computes C = A*B one
// (i,k) per cycle, then drains C rows over a valid/ready handshake.
// Ports: clk, reset (sync, active-high), bus (gemm_tile_engine_if.slave).
// Build option: GEMM_RELU_EN clamps each output column to max(C,0).
module gemm_tile_engine
    import gemm_pkg::*;
#(
    parameter int MAX_M = DEF_MAX_M,
    parameter int MAX_K = DEF_MAX_K,
    parameter int MAX_N = DEF_MAX_N
) (
    input  logic             clk,
    input  logic             reset,
    gemm_tile_engine_if.slave bus
);

    localparam int AD = MAX_M * MAX_K;
    localparam int BD = MAX_K * MAX_N;
    localparam int AW = (AD > 1) ? $clog2(AD) : 1;
    localparam int BW = (BD > 1) ? $clog2(BD) : 1;
    localparam int RW = (MAX_M > 1) ? $clog2(MAX_M) : 1;
    localparam logic [7:0] MM = 8'(MAX_M);
    localparam logic [7:0] MK = 8'(MAX_K);
    localparam logic [7:0] MN = 8'(MAX_N);

    state_t state_q, state_d;

    logic [7:0]  m_q, k_q, n_q;
    logic [7:0]  ri_q, rk_q, row_q;
    logic [15:0] cnt_q;
    logic        done_q, err_q;

    logic [15:0] mk, kn, bbase;
    logic [AW-1:0] a_idx;
    logic dims_ok, a_last, b_last, k_last, i_last, row_last;
    logic mac_clr, mac_en;

    logic signed [ELEM_W-1:0] a_mem [AD];
    logic signed [ELEM_W-1:0] b_mem [BD];
    logic [MAX_N*ACC_W-1:0]   c_mem [MAX_M];

    logic [MAX_N*ELEM_W-1:0] b_lanes;
    logic [MAX_N*ACC_W-1:0]  sum, crow, out_c;
    logic                    unused_bits;

    assign unused_bits = ^{bus.a_data[31:ELEM_W], bus.b_data[31:ELEM_W]};

    assign dims_ok = (bus.M_dim != 8'd0) && (bus.M_dim <= MM)
                  && (bus.K_dim != 8'd0) && (bus.K_dim <= MK)
                  && (bus.N_dim != 8'd0) && (bus.N_dim <= MN);

    assign mk       = {8'd0, m_q} * {8'd0, k_q};
    assign kn       = {8'd0, k_q} * {8'd0, n_q};
    assign a_last   = cnt_q == mk - 16'd1;
    assign b_last   = cnt_q == kn - 16'd1;
    assign k_last   = rk_q == k_q - 8'd1;
    assign i_last   = ri_q == m_q - 8'd1;
    assign row_last = row_q == m_q - 8'd1;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:       if (bus.in_valid && dims_ok) state_d = LOAD_A;
            LOAD_A:     if (bus.a_valid && a_last) state_d = LOAD_B;
            LOAD_B:     if (bus.b_valid && b_last) state_d = WAIT_START;
            WAIT_START: if (bus.start_compute) state_d = COMPUTE;
            COMPUTE:    if (k_last && i_last) state_d = DRAIN;
            DRAIN:      if (bus.out_ready && row_last) state_d = IDLE;
            default:    state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            m_q    <= '0;
            k_q    <= '0;
            n_q    <= '0;
            ri_q   <= '0;
            rk_q   <= '0;
            row_q  <= '0;
            cnt_q  <= '0;
            done_q <= 1'b0;
            err_q  <= 1'b0;
            for (int r = 0; r < MAX_M; r++) c_mem[r] <= '0;
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (bus.in_valid) begin
                        if (dims_ok) begin
                            m_q   <= bus.M_dim;
                            k_q   <= bus.K_dim;
                            n_q   <= bus.N_dim;
                            ri_q  <= '0;
                            rk_q  <= '0;
                            row_q <= '0;
                            cnt_q <= '0;
                            for (int r = 0; r < MAX_M; r++) c_mem[r] <= '0;
                        end else begin
                            err_q <= 1'b1;
                        end
                    end
                end
                LOAD_A: begin
                    if (bus.a_valid) cnt_q <= a_last ? '0 : cnt_q + 16'd1;
                end
                LOAD_B: begin
                    if (bus.b_valid) cnt_q <= b_last ? '0 : cnt_q + 16'd1;
                end
                COMPUTE: begin
                    if (k_last) begin
                        // row i is complete: capture the final sum this cycle
                        c_mem[ri_q[RW-1:0]] <= sum;
                        rk_q <= '0;
                        ri_q <= ri_q + 8'd1;
                    end else begin
                        rk_q <= rk_q + 8'd1;
                    end
                end
                DRAIN: begin
                    if (bus.out_ready) begin
                        row_q <= row_q + 8'd1;
                        if (row_last) done_q <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Element buffers are always rewritten before use, so no reset.
    always_ff @(posedge clk) begin
        if (state_q == LOAD_A && bus.a_valid)
            a_mem[cnt_q[AW-1:0]] <= bus.a_data[ELEM_W-1:0];
        if (state_q == LOAD_B && bus.b_valid)
            b_mem[cnt_q[BW-1:0]] <= bus.b_data[ELEM_W-1:0];
    end

    assign a_idx = AW'({8'd0, ri_q} * {8'd0, k_q} + {8'd0, rk_q});
    assign bbase = {8'd0, rk_q} * {8'd0, n_q};

    for (genvar j = 0; j < MAX_N; j++) begin : g_blane
        logic [BW-1:0] bi;
        assign bi = BW'(bbase + 16'(j));
        // lanes past N stay zero so unused C columns never accumulate
        assign b_lanes[j*ELEM_W +: ELEM_W] =
            (16'(j) < {8'd0, n_q}) ? b_mem[bi] : '0;
    end

    assign mac_en  = state_q == COMPUTE;
    assign mac_clr = (state_q == IDLE) || (mac_en && rk_q == 8'd0);

    gemm_mac_row #(
        .MAX_N (MAX_N)
    ) u_mac_row (
        .clk   (clk),
        .reset (reset),
        .clr_i (mac_clr),
        .en_i  (mac_en),
        .a_i   (a_mem[a_idx]),
        .b_i   (b_lanes),
        .sum_o (sum)
    );

    assign crow = c_mem[row_q[RW-1:0]];

    for (genvar j = 0; j < MAX_N; j++) begin : g_out
        logic [ACC_W-1:0] col;
`ifdef GEMM_RELU_EN
        assign col = relu(crow[j*ACC_W +: ACC_W]);
`else
        assign col = crow[j*ACC_W +: ACC_W];
`endif
        assign out_c[j*ACC_W +: ACC_W] = (state_q == DRAIN) ? col : '0;
    end

    assign bus.systolic_out_C = out_c;
    assign bus.out_valid      = state_q == DRAIN;
    assign bus.busy           = state_q != IDLE;
    assign bus.done           = done_q;
    assign bus.err            = err_q;

endmodule

// File: tb/tb_gemm_tile_engine.sv
// tb_gemm_tile_engine: directed self-checking bench for gemm_tile_engine.
// Honours GEMM_RELU_EN when computing expected output columns.
module tb_gemm_tile_engine;

    logic clk = 1'b0;
    logic reset;

    gemm_tile_engine_if bus ();

    gemm_tile_engine dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic check(input string tag, input logic [127:0] got,
                         input logic [127:0] exp);
        n_chk++;
        if (got !== exp)
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        else
            n_pass++;
    endtask

    function automatic logic [31:0] oc(input int v);
`ifdef GEMM_RELU_EN
        if (v < 0) return 32'd0;
`endif
        return 32'(v);
    endfunction

    function automatic logic [127:0] pack4(input int c0, input int c1,
                                           input int c2, input int c3);
        return {oc(c3), oc(c2), oc(c1), oc(c0)};
    endfunction

    task automatic start_job(input int m, input int k, input int n);
        bus.in_valid = 1'b1;
        bus.M_dim = 8'(m);
        bus.K_dim = 8'(k);
        bus.N_dim = 8'(n);
        @(negedge clk);
        bus.in_valid = 1'b0;
        check("busy_start", bus.busy, 1'b1);
    endtask

    task automatic send(input bit is_b, input int v[$], input bit disturb);
        foreach (v[i]) begin
            if (is_b) begin
                bus.b_valid = 1'b1;
                bus.b_data = {24'hA5A5A5, 8'(v[i])};
                if (disturb) begin
                    bus.a_valid = 1'b1;
                    bus.a_data = 32'd99;
                    bus.start_compute = 1'b1;
                end
            end else begin
                bus.a_valid = 1'b1;
                bus.a_data = {24'h5A5A5A, 8'(v[i])};
            end
            @(negedge clk);
        end
        bus.a_valid = 1'b0;
        bus.b_valid = 1'b0;
        bus.start_compute = 1'b0;
    endtask

    task automatic pulse_start();
        bus.start_compute = 1'b1;
        @(negedge clk);
        bus.start_compute = 1'b0;
    endtask

    task automatic drain(input logic [127:0] ev[$], input int hold_row);
        foreach (ev[r]) begin
            int t = 0;
            while (!bus.out_valid && t < 64) begin
                @(negedge clk);
                t++;
            end
            if (!bus.out_valid) begin
                check("ovalid_timeout", 1'b0, 1'b1);
                return;
            end
            check($sformatf("row%0d", r), bus.systolic_out_C, ev[r]);
            if (r == hold_row) begin
                repeat (3) begin
                    @(negedge clk);
                    check("hold_valid", bus.out_valid, 1'b1);
                    check("hold_row", bus.systolic_out_C, ev[r]);
                end
            end
            bus.out_ready = 1'b1;
            @(negedge clk);
            bus.out_ready = 1'b0;
        end
        check("done", bus.done, 1'b1);
        check("busy_end", bus.busy, 1'b0);
        @(negedge clk);
        check("done_clr", bus.done, 1'b0);
    endtask

    task automatic run_job(input int m, input int k, input int n,
                           input int av[$], input int bv[$],
                           input logic [127:0] ev[$],
                           input int hold_row, input bit disturb);
        start_job(m, k, n);
        send(1'b0, av, 1'b0);
        send(1'b1, bv, disturb);
        pulse_start();
        drain(ev, hold_row);
    endtask

    task automatic bad_job(input string tag, input int m, input int k,
                           input int n);
        bus.in_valid = 1'b1;
        bus.M_dim = 8'(m);
        bus.K_dim = 8'(k);
        bus.N_dim = 8'(n);
        @(negedge clk);
        bus.in_valid = 1'b0;
        check({tag, "_err"}, bus.err, 1'b1);
        check({tag, "_busy"}, bus.busy, 1'b0);
        @(negedge clk);
        check({tag, "_err_clr"}, bus.err, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        int qa[$];
        int qb[$];
        logic [127:0] qe[$];

        reset = 1'b1;
        bus.in_valid = 1'b0;
        bus.M_dim = '0;
        bus.K_dim = '0;
        bus.N_dim = '0;
        bus.a_valid = 1'b0;
        bus.a_data = '0;
        bus.b_valid = 1'b0;
        bus.b_data = '0;
        bus.start_compute = 1'b0;
        bus.out_ready = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_busy", bus.busy, 1'b0);
        check("rst_ovalid", bus.out_valid, 1'b0);
        check("rst_done", bus.done, 1'b0);
        check("rst_err", bus.err, 1'b0);
        check("rst_out", bus.systolic_out_C, '0);
        reset = 1'b0;
        @(negedge clk);

        bad_job("k5", 2, 5, 2);
        bad_job("n0", 2, 2, 0);

        run_job(2, 2, 2, '{1, 2, 3, 4}, '{1, 0, 0, 1},
                '{pack4(1, 2, 0, 0), pack4(3, 4, 0, 0)}, -1, 1'b0);

        qa = {};
        qb = {};
        qe = {};
        for (int i = 0; i < 16; i++) begin
            qa.push_back(-1);
            qb.push_back(2);
        end
        for (int i = 0; i < 4; i++) qe.push_back(pack4(-8, -8, -8, -8));
        run_job(4, 4, 4, qa, qb, qe, -1, 1'b0);

        run_job(3, 2, 3, '{1, 2, 3, 4, 5, 6}, '{1, 0, -1, 2, 1, 0},
                '{pack4(5, 2, -1, 0), pack4(11, 4, -3, 0),
                  pack4(17, 6, -5, 0)}, 1, 1'b0);

        run_job(2, 2, 2, '{1, 2, 3, 4}, '{5, 6, 7, 8},
                '{pack4(19, 22, 0, 0), pack4(43, 50, 0, 0)}, -1, 1'b1);

        start_job(4, 4, 4);
        send(1'b0, qa, 1'b0);
        send(1'b1, qb, 1'b0);
        pulse_start();
        repeat (3) @(negedge clk);
        check("mid_busy", bus.busy, 1'b1);
        reset = 1'b1;
        @(negedge clk);
        check("mrst_busy", bus.busy, 1'b0);
        check("mrst_ovalid", bus.out_valid, 1'b0);
        check("mrst_done", bus.done, 1'b0);
        check("mrst_err", bus.err, 1'b0);
        check("mrst_out", bus.systolic_out_C, '0);
        reset = 1'b0;
        @(negedge clk);

        run_job(1, 1, 1, '{7}, '{-3}, '{pack4(-21, 0, 0, 0)}, -1, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
